mmcm_drp_reconfig_ctrl: RTL and testbench

//  Runtime divider controller for the 5-output MMCME4 clock wrapper. Takes one request
//  (output index + integer divide) and reprograms that CLKOUTn through the DRP.

---
 rtl/mmcm_drp_pkg.sv | 32 +++
 rtl/mmcm_div_encode.sv | 25 ++
 rtl/mmcm_drp_reconfig_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mmcm_drp_reconfig_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg: shared constants, response codes and FSM states for the MMCM DRP divider controller
package mmcm_drp_pkg;

    localparam logic [6:0]  DRP_ADDR_BASE   = 7'h08;
    localparam logic [15:0] REG1_KEEP       = 16'hF000;
    localparam logic [15:0] REG2_MASK_SEL0  = 16'h7CC0;
    localparam logic [15:0] REG2_MASK_OTHER = 16'h00C0;
    localparam logic [7:0]  DIV_MAX         = 8'd126;
    localparam logic [2:0]  SEL_MAX         = 3'd4;

    typedef enum logic [1:0] {
        ERR_OK,
        ERR_ILLEGAL,
        ERR_DRDY,
        ERR_LOCK
    } rsp_err_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK,
        S_RST_HOLD,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_RST_REL,
        S_LOCK_WAIT,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/mmcm_div_encode.sv
// mmcm_div_encode: integer divide to MMCM HIGH/LOW/EDGE/NOCNT fields plus legality flag
module mmcm_div_encode
    import mmcm_drp_pkg::*;
(
    input  logic [7:0] div_i,
    output logic [5:0] high_o,
    output logic [5:0] low_o,
    output logic       edge_o,
    output logic       nocnt_o,
    output logic       legal_o
);

    logic one;

    // LOW is ceil(D/2), so odd divides put the extra half-period in LOW and set EDGE
    always_comb begin
        one     = div_i == 8'd1;
        high_o  = one ? 6'd1 : div_i[6:1];
        low_o   = one ? 6'd1 : div_i[6:1] + {5'd0, div_i[0]};
        edge_o  = one ? 1'b0 : div_i[0];
        nocnt_o = one;
        legal_o = div_i != 8'd0 && div_i <= DIV_MAX;
    end

endmodule

// File: rtl/mmcm_drp_reconfig_ctrl.sv
// mmcm_drp_reconfig_ctrl: reprograms one MMCME4 CLKOUTn divider via DRP read-modify-write under MMCM reset
module mmcm_drp_reconfig_ctrl
    import mmcm_drp_pkg::*;
#(
    parameter int RST_HOLD_CYC = 4,
    parameter int DRDY_TIMEOUT = 63,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk_in0,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_sel,
    input  logic [7:0]  req_div,
    output logic        rsp_valid,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    localparam int CNT_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT ? DRDY_TIMEOUT : LOCK_TIMEOUT) > RST_HOLD_CYC
                           ? (DRDY_TIMEOUT > LOCK_TIMEOUT ? DRDY_TIMEOUT : LOCK_TIMEOUT) : RST_HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    rsp_err_e           err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic [7:0]         div_q, div_d;
    logic               reg2_q, reg2_d;
    logic [6:0]         daddr_q, daddr_d;
    logic [15:0]        di_q, di_d;
    logic               den_q, dwe_q, mmcm_rst_q;
    logic [5:0]         enc_high, enc_low;
    logic               enc_edge, enc_nocnt, enc_legal;
    logic [6:0]         reg1_addr;
    logic [15:0]        reg2_mask, merged;
    logic               hold_end, drdy_to, lock_to;

    mmcm_div_encode u_enc (
        .div_i   (div_q),
        .high_o  (enc_high),
        .low_o   (enc_low),
        .edge_o  (enc_edge),
        .nocnt_o (enc_nocnt),
        .legal_o (enc_legal)
    );

    // Merge works directly on drp_do in the drdy cycle, so the read value never needs its own register
    assign reg1_addr = DRP_ADDR_BASE + {3'b000, sel_q, 1'b0};
    assign reg2_mask = (sel_q == 3'd0) ? REG2_MASK_SEL0 : REG2_MASK_OTHER;
    assign merged    = reg2_q ? ((drp_do & ~reg2_mask) | {8'h00, enc_edge, enc_nocnt, 6'h00})
                              : ((drp_do & REG1_KEEP) | {4'h0, enc_high, enc_low});
    assign hold_end  = cnt_q == CNT_W'(RST_HOLD_CYC - 1);
    assign drdy_to   = cnt_q == CNT_W'(DRDY_TIMEOUT);
    assign lock_to   = cnt_q == CNT_W'(LOCK_TIMEOUT);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q + CNT_W'(1);
        sel_d   = sel_q;
        div_d   = div_q;
        reg2_d  = reg2_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    state_d = S_CHK;
                    sel_d   = req_sel;
                    div_d   = req_div;
                    err_d   = ERR_OK;
                    reg2_d  = 1'b0;
                end
            end
            S_CHK: begin
                cnt_d   = '0;
                state_d = (sel_q > SEL_MAX || !enc_legal) ? S_ERR : S_RST_HOLD;
                err_d   = (sel_q > SEL_MAX || !enc_legal) ? ERR_ILLEGAL : ERR_OK;
            end
            S_RST_HOLD: begin
                if (hold_end) begin
                    state_d = S_RD;
                    daddr_d = reg1_addr;
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
                cnt_d   = '0;
            end
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    state_d = S_WR;
                    di_d    = merged;
                end else if (drdy_to) begin
                    state_d = S_ERR;
                    err_d   = ERR_DRDY;
                end
            end
            S_WR: begin
                state_d = S_WR_WAIT;
                cnt_d   = '0;
            end
            S_WR_WAIT: begin
                if (drp_drdy) begin
                    cnt_d   = '0;
                    state_d = reg2_q ? S_RST_REL : S_RD;
                    reg2_d  = 1'b1;
                    daddr_d = reg2_q ? daddr_q : reg1_addr + 7'd1;
                end else if (drdy_to) begin
                    state_d = S_ERR;
                    err_d   = ERR_DRDY;
                end
            end
            S_RST_REL: begin
                if (hold_end) begin
                    state_d = S_LOCK_WAIT;
                    cnt_d   = '0;
                end
            end
            S_LOCK_WAIT: begin
                if (mmcm_locked) begin
                    state_d = S_DONE;
                end else if (lock_to) begin
                    state_d = S_ERR;
                    err_d   = ERR_LOCK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // DRP strobes and MMCM reset are decoded from the next state so they leave flops glitch-free
    always_ff @(posedge clk_in0) begin
        if (reset) begin
            state_q    <= S_IDLE;
            err_q      <= ERR_OK;
            cnt_q      <= '0;
            sel_q      <= '0;
            div_q      <= '0;
            reg2_q     <= 1'b0;
            daddr_q    <= '0;
            di_q       <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            mmcm_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            div_q      <= div_d;
            reg2_q     <= reg2_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
            den_q      <= state_d == S_RD || state_d == S_WR;
            dwe_q      <= state_d == S_WR;
            mmcm_rst_q <= state_d inside {S_RST_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_RST_REL};
        end
    end

    assign req_ready = state_q == S_IDLE;
    assign busy      = !req_ready;
    assign rsp_valid = state_q == S_DONE || state_q == S_ERR;
    assign rsp_err   = rsp_valid ? err_q : ERR_OK;
    assign drp_daddr = daddr_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign drp_di    = di_q;
    assign mmcm_rst  = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// tb_mmcm_drp_reconfig_ctrl: directed scoreboard bench with DRP register-file and lock models
module tb_mmcm_drp_reconfig_ctrl;

    localparam int RST_HOLD = 4;
    localparam int DRDY_TO  = 63;
    localparam int LOCK_TO  = 65535;

    typedef struct { logic [1:0] err; int dens; int acc_lat; int den_lat; } exp_t;
    typedef struct { logic [6:0] addr; logic [15:0] data; } wr_t;

    logic        clk = 0, reset = 1, req_valid = 0;
    logic [2:0]  req_sel = 0;
    logic [7:0]  req_div = 0;
    logic [15:0] drp_do = 0;
    logic        drp_drdy = 0, mmcm_locked = 0;
    logic        req_ready, rsp_valid, busy, drp_den, drp_dwe, mmcm_rst;
    logic [1:0]  rsp_err;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;

    exp_t        sb[$];
    wr_t         wq[$];
    logic [15:0] mem [0:127];
    int checks = 0, failures = 0, cyc = 0, exp_total = 0;
    int rsp_cnt = 0, den_total = 0, den_cnt = 0, acc_cyc = 0, den_cyc = 0, rsp_cyc = 0, rst_fall_cyc = 0;
    int lat = 0, lock_ctr = 0, lock_n = 3;
    bit pend = 0, p_we = 0, no_drdy = 0, lock_low = 0, prev_den = 0, prev_rst = 0, rst_seen = 0, after_rsp = 0;
    logic [6:0]  p_addr = 0;
    logic [15:0] p_di = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmcm_drp_reconfig_ctrl #(
        .RST_HOLD_CYC (RST_HOLD),
        .DRDY_TIMEOUT (DRDY_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk_in0     (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_div     (req_div),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .drp_daddr   (drp_daddr),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    function automatic void push_exp(input logic [1:0] err, input int dens, input int acc, input int dl);
        exp_t e;
        e.err = err; e.dens = dens; e.acc_lat = acc; e.den_lat = dl;
        sb.push_back(e);
        exp_total++;
    endfunction

    function automatic void push_wr(input logic [6:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        wq.push_back(w);
    endfunction

    task automatic do_req(input logic [2:0] s, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", req_ready, 1);
        req_valid = 1; req_sel = s; req_div = d; acc_cyc = cyc;
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (rsp_cnt < exp_total && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("rsp_arrived", rsp_cnt >= exp_total, 1);
    endtask

    // DRP register file with 1..5 cycle drdy latency, lock model, protocol checks and scoreboard pops
    always @(negedge clk) begin : model
        exp_t e;
        wr_t  w;
        drp_drdy = 0;
        if (reset) begin
            pend = 0; den_cnt = 0; rst_seen = 0; prev_den = 0; prev_rst = 0; after_rsp = 0;
            mmcm_locked = 0; lock_ctr = 0;
        end else begin
            if (after_rsp) chk("ready_after_rsp", req_ready, 1);
            after_rsp = 0;
            if (drp_dwe) chk("dwe_without_den", drp_den, 1);
            if (drp_den) begin
                chk("den_outstanding", pend, 0);
                chk("den_pulse", prev_den, 0);
                chk("rst_during_drp", mmcm_rst, 1);
            end
            if (pend) begin
                chk("drp_addr_stable", drp_daddr, p_addr);
                chk("drp_di_stable", drp_di, p_di);
                if (!no_drdy) lat--;
                if (!no_drdy && lat == 0) begin
                    drp_drdy = 1;
                    pend = 0;
                    if (p_we) begin
                        mem[p_addr] = p_di;
                        chk("wr_expected", wq.size() > 0, 1);
                        if (wq.size() > 0) begin
                            w = wq.pop_front();
                            chk("wr_addr", p_addr, w.addr);
                            chk("wr_data", p_di, w.data);
                        end
                    end else drp_do = mem[p_addr];
                end
            end
            if (drp_den) begin
                pend = 1; p_we = drp_dwe; p_addr = drp_daddr; p_di = drp_di;
                lat = $urandom_range(5, 1);
                den_cnt++; den_total++; den_cyc = cyc;
            end
            if (mmcm_rst) rst_seen = 1;
            if (prev_rst && !mmcm_rst) rst_fall_cyc = cyc;
            if (mmcm_rst) begin
                mmcm_locked = 0; lock_ctr = 0;
            end else if (!lock_low && !mmcm_locked) begin
                if (lock_ctr >= lock_n) mmcm_locked = 1;
                else lock_ctr++;
            end
            if (rsp_valid) begin
                rsp_cnt++; rsp_cyc = cyc; after_rsp = 1; pend = 0;
                chk("rsp_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_err", rsp_err, e.err);
                    chk("den_count", den_cnt, e.dens);
                    chk("rst_used", rst_seen, e.dens > 0);
                    chk("rst_low_at_rsp", mmcm_rst, 0);
                    chk("busy_at_rsp", busy, 1);
                    chk("ready_low_at_rsp", req_ready, 0);
                    if (e.acc_lat >= 0) chk("accept_to_rsp", cyc - acc_cyc, e.acc_lat);
                    if (e.den_lat >= 0) chk("den_to_rsp", cyc - den_cyc, e.den_lat);
                end
                den_cnt = 0; rst_seen = 0;
            end
            prev_den = drp_den;
            prev_rst = mmcm_rst;
        end
    end

    initial begin
        int base;
        int n;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[7'h0C] = 16'hF000; mem[7'h0D] = 16'h12C5;
        mem[7'h08] = 16'h5FFF; mem[7'h09] = 16'h7CFF;
        mem[7'h10] = 16'hABCD; mem[7'h11] = 16'hFFFF;
        mem[7'h0A] = 16'h1234; mem[7'h0B] = 16'h00C0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_den", drp_den, 0);
        chk("rst_dwe", drp_dwe, 0);
        chk("rst_daddr", drp_daddr, 0);
        chk("rst_di", drp_di, 0);
        chk("rst_mmcm_rst", mmcm_rst, 0);
        reset = 0;

        push_wr(7'h0C, 16'hF3CF); push_wr(7'h0D, 16'h1205); push_exp(0, 4, -1, -1);
        do_req(3'd2, 8'd30); wait_rsp(300);
        push_wr(7'h08, 16'h5041); push_wr(7'h09, 16'h007F); push_exp(0, 4, -1, -1);
        do_req(3'd0, 8'd1); wait_rsp(300);
        push_wr(7'h10, 16'hA0C4); push_wr(7'h11, 16'hFFBF); push_exp(0, 4, -1, -1);
        do_req(3'd4, 8'd7);
        repeat (3) begin
            @(negedge clk);
            req_valid = 1; req_sel = 3'd5; req_div = 8'd0;
        end
        @(negedge clk);
        req_valid = 0;
        wait_rsp(300);
        push_wr(7'h0A, 16'h1FFF); push_wr(7'h0B, 16'h0000); push_exp(0, 4, -1, -1);
        do_req(3'd1, 8'd126); wait_rsp(300);

        push_exp(1, 0, 2, -1); do_req(3'd5, 8'd30); wait_rsp(20);
        push_exp(1, 0, 2, -1); do_req(3'd0, 8'd0); wait_rsp(20);
        push_exp(1, 0, 2, -1); do_req(3'd1, 8'd127); wait_rsp(20);

        no_drdy = 1;
        push_exp(2, 1, -1, DRDY_TO + 2); do_req(3'd1, 8'd2); wait_rsp(300);
        no_drdy = 0;

        no_drdy = 1;
        base = den_total;
        do_req(3'd2, 8'd9);
        n = 0;
        while (den_total == base && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("abort_den_seen", den_total > base, 1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("abort_ready", req_ready, 1);
        chk("abort_mmcm_rst", mmcm_rst, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_den", drp_den, 0);
        reset = 0;
        no_drdy = 0;
        repeat (10) @(negedge clk);

        lock_low = 1;
        push_wr(7'h0E, 16'h0082); push_wr(7'h0F, 16'h0000); push_exp(3, 4, -1, -1);
        do_req(3'd3, 8'd4); wait_rsp(LOCK_TO + 400);
        lock_low = 0;
        chk("lock_timeout_cycles", (rsp_cyc - rst_fall_cyc) inside {[LOCK_TO : LOCK_TO + 2]}, 1);
        push_wr(7'h0E, 16'h0083); push_wr(7'h0F, 16'h0080); push_exp(0, 4, -1, -1);
        do_req(3'd3, 8'd5); wait_rsp(300);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("wq_empty", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
